// File: rtl/bus_periph_pkg.sv
// Shared definitions for the 0x4000_00xx peripheral map: addresses, UCON bit
// positions and the UART transmit state encoding.
package bus_periph_pkg;

   localparam logic [31:0] TIMER_TH_ADDR  = 32'h4000_0000;
   localparam logic [31:0] TIMER_TL_ADDR  = 32'h4000_0004;
   localparam logic [31:0] TIMER_CON_ADDR = 32'h4000_0008;
   localparam logic [31:0] LED_ADDR       = 32'h4000_000C;
   localparam logic [31:0] SWITCH_ADDR    = 32'h4000_0010;
   localparam logic [31:0] DIGIT_ADDR     = 32'h4000_0014;
   localparam logic [31:0] TXD_ADDR       = 32'h4000_0018;
   localparam logic [31:0] RXD_ADDR       = 32'h4000_001C;
   localparam logic [31:0] UCON_ADDR      = 32'h4000_0020;

   localparam int UCON_BUSY_BIT    = 0;
   localparam int UCON_FULL_BIT    = 1;
   localparam int UCON_EMPTY_BIT   = 2;
   localparam int UCON_OVF_BIT     = 3;
   localparam int UCON_IRQ_EN_BIT  = 4;
   localparam int UCON_TX_DONE_BIT = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bus_uart_tx_responder.sv
// Bus responder exposing TXD and UCON: queues bytes in a small FIFO and sends
// them as 8N1 frames on tx, with a sticky tx_done flag driving a level irq.
module bus_uart_tx_responder #(
   parameter int          CLK_HZ     = 100000000,
   parameter int          BAUD       = 9600,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] TXD_ADDR   = bus_periph_pkg::TXD_ADDR,
   parameter logic [31:0] UCON_ADDR  = bus_periph_pkg::UCON_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        Mem_rd,
   input  logic        Mem_wr,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        hit,
   output logic        tx,
   output logic        irq
);

   import bus_periph_pkg::*;

   localparam int DIVISOR = CLK_HZ / BAUD;
   localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
   localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

   logic             txd_sel;
   logic             ucon_sel;
   logic             txd_wr;
   logic             ucon_wr;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic [FCW-1:0]   fifo_count;

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             baud_done;
   logic             frame_end;

   logic             overflow;
   logic             irq_en;
   logic             tx_done;
   logic [31:0]      ucon_status;
   logic             unused_bits;

   assign txd_sel  = (addr == TXD_ADDR);
   assign ucon_sel = (addr == UCON_ADDR);
   assign hit      = txd_sel || ucon_sel;
   assign txd_wr   = Mem_wr && txd_sel;
   assign ucon_wr  = Mem_wr && ucon_sel;

   assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;
   assign baud_done = (baud_cnt == CNT_MAX);
   assign frame_end = (state == TX_STOP) && baud_done;

   assign irq = irq_en && tx_done;

   assign unused_bits = ^{Write_data[31:8], fifo_count};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (txd_wr),
      .pop   (fifo_pop),
      .din   (Write_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      ucon_status                   = '0;
      ucon_status[UCON_BUSY_BIT]    = (state != TX_IDLE);
      ucon_status[UCON_FULL_BIT]    = fifo_full;
      ucon_status[UCON_EMPTY_BIT]   = fifo_empty;
      ucon_status[UCON_OVF_BIT]     = overflow;
      ucon_status[UCON_IRQ_EN_BIT]  = irq_en;
      ucon_status[UCON_TX_DONE_BIT] = tx_done;
   end

   always_comb begin
      Read_data = '0;
      if (Mem_rd && ucon_sel) begin
         Read_data = ucon_status;
      end
   end

   // Hardware sets are applied after the W1C clears so a coincident set wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         irq_en   <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         if (ucon_wr) begin
            irq_en <= Write_data[UCON_IRQ_EN_BIT];
            if (Write_data[UCON_OVF_BIT]) begin
               overflow <= 1'b0;
            end
            if (Write_data[UCON_TX_DONE_BIT]) begin
               tx_done <= 1'b0;
            end
         end
         if (txd_wr && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end
         if (frame_end) begin
            tx_done <= 1'b1;
         end
      end
   end

   // tx is loaded with the level for the state being entered, so the line
   // changes exactly on the edge that starts each bit period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= TX_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_uart_tx_responder.sv
// Directed bench for bus_uart_tx_responder at DIVISOR=10: reset, framing,
// FIFO overflow, UCON flags, irq, address decode and back-to-back frames.
module tb_bus_uart_tx_responder;

   localparam logic [31:0] TXD  = 32'h4000_0018;
   localparam logic [31:0] UCON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        Mem_rd;
   logic        Mem_wr;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        hit;
   logic        tx;
   logic        irq;

   int pass_count  = 0;
   int total_count = 0;

   logic [255:0] line;
   logic [31:0]  rdata;
   logic         rhit;

   bus_uart_tx_responder #(
      .CLK_HZ     (1000),
      .BAUD       (100),
      .FIFO_DEPTH (4),
      .TXD_ADDR   (TXD),
      .UCON_ADDR  (UCON)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .Mem_rd     (Mem_rd),
      .Mem_wr     (Mem_wr),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .hit        (hit),
      .tx         (tx),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_count++;
      assert (observed === expected) begin
         pass_count++;
      end else begin
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      addr       = a;
      Write_data = d;
      Mem_wr     = 1'b1;
      step();
      Mem_wr     = 1'b0;
      addr       = '0;
      Write_data = '0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d, output logic h);
      addr   = a;
      Mem_rd = 1'b1;
      #1;
      d      = Read_data;
      h      = hit;
      Mem_rd = 1'b0;
      addr   = '0;
   endtask

   initial begin
      logic [9:0]  grp;
      logic [9:0]  fexp;
      logic [7:0]  byte1;
      logic [7:0]  byte2;
      logic [11:0] gap;
      int          k;

      reset      = 1'b0;
      addr       = '0;
      Mem_rd     = 1'b0;
      Mem_wr     = 1'b0;
      Write_data = '0;

      step();
      step();
      checkOutput("reset_tx", {31'b0, tx}, 32'd1);
      checkOutput("reset_irq", {31'b0, irq}, 32'd0);
      reset = 1'b1;
      step();
      busRead(UCON, rdata, rhit);
      checkOutput("idle_ucon", rdata, 32'h0000_0004);
      checkOutput("ucon_hit", {31'b0, rhit}, 32'd1);

      // Single 0x55 frame with exact per-bit timing
      applyStimulus(TXD, 32'hFFFF_FF55);
      checkOutput("tx_before_pop", {31'b0, tx}, 32'd1);
      busRead(UCON, rdata, rhit);
      checkOutput("ucon_queued", rdata, 32'h0000_0000);
      step();
      checkOutput("tx_start_fall", {31'b0, tx}, 32'd0);
      busRead(UCON, rdata, rhit);
      checkOutput("ucon_busy", rdata, 32'h0000_0005);
      for (int i = 0; i < 100; i++) begin
         line[i] = tx;
         step();
      end
      fexp = {1'b1, 8'h55, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int j = 0; j < 10; j++) begin
            grp[j] = line[b*10 + j];
         end
         checkOutput($sformatf("frame55_bit%0d", b), {22'b0, grp}, {22'b0, {10{fexp[b]}}});
      end
      checkOutput("tx_after_frame", {31'b0, tx}, 32'd1);
      busRead(UCON, rdata, rhit);
      checkOutput("ucon_tx_done", rdata, 32'h0000_0024);
      applyStimulus(UCON, 32'h0000_0020);
      busRead(UCON, rdata, rhit);
      checkOutput("tx_done_w1c", rdata, 32'h0000_0004);

      // Fill past capacity, then overflow and its W1C clear
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(TXD, i);
      end
      busRead(UCON, rdata, rhit);
      checkOutput("fifo_full_no_ovf", rdata, 32'h0000_0003);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(TXD, 32'h0000_00E0 + i);
      end
      busRead(UCON, rdata, rhit);
      checkOutput("overflow_set", rdata, 32'h0000_000B);
      applyStimulus(UCON, 32'h0000_0008);
      busRead(UCON, rdata, rhit);
      checkOutput("overflow_w1c", rdata, 32'h0000_0003);

      // Asynchronous reset while the start bit is on the line
      checkOutput("tx_mid_frame", {31'b0, tx}, 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("async_reset_tx", {31'b0, tx}, 32'd1);
      busRead(UCON, rdata, rhit);
      checkOutput("async_reset_ucon", rdata, 32'h0000_0004);
      reset = 1'b1;
      step();

      // irq follows tx_done once enabled
      applyStimulus(UCON, 32'h0000_0010);
      checkOutput("irq_en_only", {31'b0, irq}, 32'd0);
      busRead(UCON, rdata, rhit);
      checkOutput("ucon_irq_en", rdata, 32'h0000_0014);
      applyStimulus(TXD, 32'h0000_0081);
      k = 0;
      while (!irq && k < 300) begin
         step();
         k++;
      end
      checkOutput("irq_latency", k, 32'd101);
      busRead(UCON, rdata, rhit);
      checkOutput("ucon_irq_done", rdata, 32'h0000_0034);
      applyStimulus(UCON, 32'h0000_0030);
      checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
      busRead(UCON, rdata, rhit);
      checkOutput("irq_en_kept", rdata, 32'h0000_0014);

      // Address decode: unmapped neighbours, TXD read, UCON without Mem_rd
      busRead(32'h4000_001C, rdata, rhit);
      checkOutput("unmapped1c_hit", {31'b0, rhit}, 32'd0);
      checkOutput("unmapped1c_data", rdata, 32'd0);
      busRead(32'h4000_0000, rdata, rhit);
      checkOutput("unmapped00_hit", {31'b0, rhit}, 32'd0);
      checkOutput("unmapped00_data", rdata, 32'd0);
      busRead(TXD, rdata, rhit);
      checkOutput("txd_read_hit", {31'b0, rhit}, 32'd1);
      checkOutput("txd_read_data", rdata, 32'd0);
      addr = UCON;
      #1;
      checkOutput("ucon_no_rd", Read_data, 32'd0);
      addr = '0;
      applyStimulus(32'h4000_001C, 32'h0000_00AA);
      applyStimulus(32'h4000_0000, 32'h0000_00AA);
      step();
      step();
      checkOutput("unmapped_tx_idle", {31'b0, tx}, 32'd1);
      busRead(UCON, rdata, rhit);
      checkOutput("unmapped_no_push", rdata, 32'h0000_0014);

      // Back-to-back frames 0xA5 then 0x3C
      applyStimulus(TXD, 32'h0000_00A5);
      applyStimulus(TXD, 32'h0000_003C);
      for (int i = 0; i < 201; i++) begin
         line[i] = tx;
         step();
      end
      for (int i = 0; i < 8; i++) begin
         byte1[i] = line[10 + 10*i + 5];
         byte2[i] = line[111 + 10*i + 5];
      end
      for (int j = 0; j < 12; j++) begin
         gap[j] = line[90 + j];
      end
      for (int j = 0; j < 10; j++) begin
         grp[j] = line[191 + j];
      end
      checkOutput("b2b_start1", {31'b0, line[0]}, 32'd0);
      checkOutput("b2b_byte1", {24'b0, byte1}, 32'h0000_00A5);
      checkOutput("b2b_gap", {20'b0, gap}, 32'h0000_07FF);
      checkOutput("b2b_byte2", {24'b0, byte2}, 32'h0000_003C);
      checkOutput("b2b_stop2", {22'b0, grp}, 32'h0000_03FF);

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
